cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
Memory-side responder for the direct-mapped data cache. Accepts miss-refill and write-through requests from the cache over a valid/ready channel and performs the access on synchronous data memory with fixed latency. Returns a refill response carrying the set, tag and data word that the cache installs as {V=1, tag, data}. Sits between the cache and the data memory.

Parameters:
DATA_WIDTH, 32, width of a data word
ADDRESS_WIDTH, 32, byte-address width
SET_BITS, 3, set-index bits (8 sets); TAG_WIDTH = ADDRESS_WIDTH-SET_BITS-2 = 27
MEM_LATENCY, 2, cycles from the memory-issue edge to valid mem_rdata; legal range is 1 to 15

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  cache has a miss or store request
req_ready  out  1  controller can accept a request
req_we  in  1  1 = write-through store, 0 = refill read
req_addr  in  ADDRESS_WIDTH  byte address; bits [1:0] ignored
req_wdata  in  DATA_WIDTH  store data
rsp_valid  out  1  response available
rsp_ready  in  1  cache accepts the response
rsp_write  out  1  response acknowledges a write
rsp_set  out  SET_BITS  req_addr[SET_BITS+1:2] of the served request
rsp_tag  out  TAG_WIDTH  req_addr[ADDRESS_WIDTH-1:SET_BITS+2]
rsp_data  out  DATA_WIDTH  refill word, or the store data for writes
mem_en  out  1  memory access strobe, high one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDRESS_WIDTH  word-aligned address, {req_addr[31:2],2'b00}
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after the issue edge

Behaviour:
- Reset (async assert, sync release): state IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_write=0, rsp_set=0, rsp_tag=0, rsp_data=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wait counter=0.
- FSM states: IDLE, ISSUE, WAIT, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready at edge E0, latch addr, we and wdata. Go to WRITE if we=1, else ISSUE.
- ISSUE: one cycle, mem_en=1, mem_we=0. Load counter=MEM_LATENCY. Go to WAIT.
- WAIT: decrement the counter each cycle. At the edge where it reaches 0 (edge E0+MEM_LATENCY+1), capture mem_rdata into rsp_data and go to RESP.
- WRITE: one cycle, mem_en=1, mem_we=1, mem_wdata=latched data. Go to RESP with rsp_write=1 and rsp_data=wdata.
- RESP: rsp_valid=1. Hold rsp_* stable until rsp_valid&rsp_ready, then go to IDLE.
- req_ready=0 in every state except IDLE. Only one outstanding request. The requester holds req_* while req_ready=0.
- Refill latency with rsp_ready=1: rsp_valid first high MEM_LATENCY+2 cycles after accept (4 cycles at default).
- Write latency: rsp_valid high 2 cycles after accept.
- Throughput: the next request can be accepted the cycle after the response handshake, never in the same cycle.
- rst_n low mid-transaction: the request is dropped, no memory strobe follows, and outputs return to reset values immediately.
- mem_en is never high for more than one cycle per request.

Optional Feature:
Macro POSTED_WRITE_EN.
- Defined: stores produce no response. WRITE returns directly to IDLE, so req_ready is high again 2 cycles after accept and rsp_write is tied to 0.
- Not defined: every store produces an acknowledging response, as described in Behaviour.

Decomposition:
- Package cache_pkg holds:
  - TAG_WIDTH/SET_BITS constants;
  - the state enum refill_state_t;
  - the struct cache_line_t {logic v; tag; data};
  - the address-split helper functions get_tag and get_set.
- One natural sub-module, mem_latency_counter: loadable down-counter with a done flag, parameterised by MEM_LATENCY.

Test Plan:
- Reset, then release with no stimulus -> req_ready=1, rsp_valid=0, mem_en=0 for 10 cycles.
- Read req_addr=0x0000_00A4, memory returns 0xDEAD_BEEF, MEM_LATENCY=2 -> single mem_en at 0x0000_00A4, rsp_valid 4 cycles after accept, rsp_set=1, rsp_tag=0x5, rsp_data=0xDEAD_BEEF.
- Write req_addr=0x0000_0010, wdata=0x1234_5678 -> mem_en=mem_we=1 for one cycle with matching address/data, and rsp_write=1 after 2 cycles (with POSTED_WRITE_EN: no rsp_valid and req_ready high after 2 cycles).
- Hold rsp_ready=0 for 5 cycles during a read response -> rsp_* stable, req_ready=0, new req_valid ignored, no extra mem_en.
- Assert rst_n=0 in the WAIT state -> outputs zero immediately, and no response appears after release.
- Back-to-back read then write with rsp_ready=1 -> second accept exactly 1 cycle after the first response handshake, memory order preserved.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache refill controller.
// Covers the address split, the FSM state type and the installed cache line.
package cache_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned ADDRESS_WIDTH = 32;
    localparam int unsigned SET_BITS      = 3;
    localparam int unsigned TAG_WIDTH     = ADDRESS_WIDTH - SET_BITS - 2;
    localparam int unsigned CNT_WIDTH     = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } refill_state_t;

    typedef struct packed {
        logic                  v;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } cache_line_t;

    function automatic logic [TAG_WIDTH-1:0] get_tag(input logic [ADDRESS_WIDTH-1:0] addr);
        return addr[ADDRESS_WIDTH-1:SET_BITS+2];
    endfunction

    function automatic logic [SET_BITS-1:0] get_set(input logic [ADDRESS_WIDTH-1:0] addr);
        return addr[SET_BITS+1:2];
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Request/response channel between the data cache and the refill controller.
interface cache_refill_ctrl_if;
    import cache_pkg::*;

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic                     rsp_write;
    logic [SET_BITS-1:0]      rsp_set;
    logic [TAG_WIDTH-1:0]     rsp_tag;
    logic [DATA_WIDTH-1:0]    rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_write, rsp_set, rsp_tag, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_write, rsp_set, rsp_tag, rsp_data
    );

endinterface

// File: rtl/cache_refill_ctrl_mem_latency_counter.sv
// Loadable down-counter timing the memory read latency.
// done_c flags the cycle whose decrement brings the count to zero.
module mem_latency_counter
    import cache_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic done_c
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_WIDTH'(MEM_LATENCY);
        end else if (dec && (count != '0)) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    assign done_c = dec && (count == CNT_WIDTH'(1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Memory-side responder serving cache refills and write-through stores.
// Optional macro POSTED_WRITE_EN: stores complete without a response.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cache_refill_ctrl_if.slave       bus,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    refill_state_t state, state_n;

    logic                     req_ready, req_ready_n;
    logic                     rsp_valid, rsp_valid_n;
    logic                     rsp_write, rsp_write_n;
    logic [SET_BITS-1:0]      rsp_set, rsp_set_n;
    logic [TAG_WIDTH-1:0]     rsp_tag, rsp_tag_n;
    logic [DATA_WIDTH-1:0]    rsp_data, rsp_data_n;
    logic                     mem_en_n, mem_we_n;
    logic [ADDRESS_WIDTH-1:0] mem_addr_n;
    logic [DATA_WIDTH-1:0]    mem_wdata_n;
    logic                     cnt_load_c, cnt_dec_c, cnt_done_c;

    // byte-offset bits carry no meaning for word accesses
    logic unused_addr_lsb_c;
    assign unused_addr_lsb_c = ^bus.req_addr[1:0];

    mem_latency_counter #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_lat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_load_c),
        .dec    (cnt_dec_c),
        .done_c (cnt_done_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_set   <= '0;
            rsp_tag   <= '0;
            rsp_data  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_write <= rsp_write_n;
            rsp_set   <= rsp_set_n;
            rsp_tag   <= rsp_tag_n;
            rsp_data  <= rsp_data_n;
            mem_en    <= mem_en_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
        end
    end

    // Next state and next output values; mem_addr/mem_wdata double as the request latch
    always_comb begin
        state_n     = state;
        req_ready_n = req_ready;
        rsp_valid_n = rsp_valid;
        rsp_write_n = rsp_write;
        rsp_set_n   = rsp_set;
        rsp_tag_n   = rsp_tag;
        rsp_data_n  = rsp_data;
        mem_en_n    = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        cnt_load_c  = 1'b0;
        cnt_dec_c   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid && req_ready) begin
                    req_ready_n = 1'b0;
                    mem_en_n    = 1'b1;
                    mem_we_n    = bus.req_we;
                    mem_addr_n  = {bus.req_addr[ADDRESS_WIDTH-1:2], 2'b00};
                    if (bus.req_we) begin
                        mem_wdata_n = bus.req_wdata;
                        state_n     = WRITE;
                    end else begin
                        state_n     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_load_c = 1'b1;
                state_n    = WAIT;
            end
            WAIT: begin
                cnt_dec_c = 1'b1;
                if (cnt_done_c) begin
                    rsp_valid_n = 1'b1;
                    rsp_write_n = 1'b0;
                    rsp_set_n   = get_set(mem_addr);
                    rsp_tag_n   = get_tag(mem_addr);
                    rsp_data_n  = mem_rdata;
                    state_n     = RESP;
                end
            end
            WRITE: begin
`ifdef POSTED_WRITE_EN
                req_ready_n = 1'b1;
                state_n     = IDLE;
`else
                rsp_valid_n = 1'b1;
                rsp_write_n = 1'b1;
                rsp_set_n   = get_set(mem_addr);
                rsp_tag_n   = get_tag(mem_addr);
                rsp_data_n  = mem_wdata;
                state_n     = RESP;
`endif
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    req_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
`ifdef POSTED_WRITE_EN
    assign bus.rsp_write = 1'b0;
    logic unused_rsp_write_c;
    assign unused_rsp_write_c = rsp_write;
`else
    assign bus.rsp_write = rsp_write;
`endif
    assign bus.rsp_set   = rsp_set;
    assign bus.rsp_tag   = rsp_tag;
    assign bus.rsp_data  = rsp_data;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized self-checking bench for cache_refill_ctrl against an address-level memory model.
module tb_cache_refill_ctrl;
    import cache_pkg::*;

    localparam int unsigned LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cache_refill_ctrl_if bus ();
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    cache_refill_ctrl #(.MEM_LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] init_word(input int unsigned i);
        return 32'(i * 32'h9E37_79B9) ^ 32'hC3A5_0F1E;
    endfunction

    // Environment memory: fixed read latency, garbage on rdata outside the valid slot
    logic [31:0] mem_arr [0:1023];
    logic [31:0] rd_pipe [0:15];
    int          strobe_cnt  = 0;
    int          en_run_err  = 0;
    logic        prev_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 1024; i++) mem_arr[i] <= init_word(i);
            prev_en <= 1'b0;
        end else begin
            if (mem_en && mem_we) mem_arr[mem_addr[11:2]] <= mem_wdata;
            if (mem_en) strobe_cnt <= strobe_cnt + 1;
            if (mem_en && prev_en) en_run_err <= en_run_err + 1;
            prev_en    <= mem_en;
            rd_pipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[11:2]] : $urandom();
            for (int i = 1; i < 16; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // Reference model: word-addressed store, unwritten words hold the power-up pattern
    logic [31:0] ref_mem [logic [29:0]];

    function automatic logic [31:0] exp_read(input logic [31:0] addr);
        logic [29:0] k;
        k = 30'(addr >> 2);
        if (ref_mem.exists(k)) return ref_mem[k];
        return init_word(32'(k % 1024));
    endfunction

    function automatic logic [2:0]  exp_set(input logic [31:0] a); return 3'((a >> 2) % 8); endfunction
    function automatic logic [26:0] exp_tag(input logic [31:0] a); return 27'(a >> 5);      endfunction

    logic        obs_timeout, obs_first_en, obs_first_we, obs_busy_ready;
    logic [31:0] obs_first_addr, obs_first_wdata, obs_data;
    logic [2:0]  obs_set;
    logic [26:0] obs_tag;
    logic        obs_write, obs_stable, obs_ready_hs, obs_valid_hs;
    logic        obs_ready_post, obs_valid_post;
    int          obs_lat, obs_strobes;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction and records what the DUT did; checks are made by the callers
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall);
        int s0, n;
        s0 = strobe_cnt;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.rsp_ready = 1'b0;
        obs_timeout = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 50) begin tick(); n++; end
        if (n >= 50) obs_timeout = 1'b1;
        tick();
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom()); bus.req_addr = $urandom();
        bus.req_wdata = $urandom();
        obs_first_en = mem_en; obs_first_we = mem_we;
        obs_first_addr = mem_addr; obs_first_wdata = mem_wdata;
        obs_busy_ready = bus.req_ready;
`ifdef POSTED_WRITE_EN
        if (we) begin
            tick();
            obs_ready_post = bus.req_ready;
            obs_valid_post = bus.rsp_valid;
            obs_strobes    = strobe_cnt - s0;
            return;
        end
`endif
        n = 0;
        while (!bus.rsp_valid && n < 50) begin tick(); n++; end
        obs_lat = n;
        obs_set = bus.rsp_set; obs_tag = bus.rsp_tag; obs_data = bus.rsp_data;
        obs_write = bus.rsp_write;
        obs_stable = 1'b1;
        if (stall > 0) bus.req_valid = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_set !== obs_set || bus.rsp_tag !== obs_tag ||
                bus.rsp_data !== obs_data || bus.rsp_write !== obs_write || bus.req_ready !== 1'b0)
                obs_stable = 1'b0;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        obs_ready_hs = bus.req_ready;
        obs_valid_hs = bus.rsp_valid;
        obs_strobes  = strobe_cnt - s0;
    endtask

    task automatic test_reset();
        logic [130:0] rv;
        repeat (2) tick();
        rv = {bus.req_ready, bus.rsp_valid, bus.rsp_write, bus.rsp_set, bus.rsp_tag, bus.rsp_data,
              mem_en, mem_we, mem_addr, mem_wdata};
        n_vec++;
        if (rv !== {1'b1, 130'b0}) begin
            n_err++; $display("FAIL reset_values got %h want %h", rv, {1'b1, 130'b0});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if ({bus.req_ready, bus.rsp_valid, mem_en} !== 3'b100) begin
                n_err++;
                $display("FAIL idle_quiet cycle %0d got %b want 100", i,
                         {bus.req_ready, bus.rsp_valid, mem_en});
            end
        end
    endtask

    task automatic test_read();
        do_txn(1'b1, 32'h0000_00A4, 32'hDEAD_BEEF, 0);
        ref_mem[30'(32'h0000_00A4 >> 2)] = 32'hDEAD_BEEF;
        do_txn(1'b0, 32'h0000_00A4, 32'h0, 0);
        n_vec++;
        if ({obs_first_en, obs_first_we, obs_first_addr} !== {2'b10, 32'h0000_00A4}) begin
            n_err++; $display("FAIL read_strobe got %h want %h",
                              {obs_first_en, obs_first_we, obs_first_addr}, {2'b10, 32'h0000_00A4});
        end
        n_vec++;
        if (obs_lat != LAT + 1) begin
            n_err++; $display("FAIL read_latency got %0d cycles want %0d", obs_lat + 1, LAT + 2);
        end
        n_vec++;
        if ({obs_set, obs_tag} !== {3'd1, 27'h5}) begin
            n_err++; $display("FAIL read_set_tag got %h/%h want 1/5", obs_set, obs_tag);
        end
        n_vec++;
        if (obs_data !== exp_read(32'h0000_00A4) || obs_write !== 1'b0) begin
            n_err++; $display("FAIL read_data got %h w=%b want %h w=0", obs_data, obs_write,
                              exp_read(32'h0000_00A4));
        end
        n_vec++;
        if (obs_strobes != 1) begin
            n_err++; $display("FAIL read_strobes got %0d want 1", obs_strobes);
        end
    endtask

    task automatic test_write();
        do_txn(1'b1, 32'h0000_0010, 32'h1234_5678, 0);
        ref_mem[30'(32'h0000_0010 >> 2)] = 32'h1234_5678;
        n_vec++;
        if ({obs_first_en, obs_first_we, obs_first_addr, obs_first_wdata} !==
            {2'b11, 32'h0000_0010, 32'h1234_5678}) begin
            n_err++; $display("FAIL write_strobe got %h want %h",
                {obs_first_en, obs_first_we, obs_first_addr, obs_first_wdata},
                {2'b11, 32'h0000_0010, 32'h1234_5678});
        end
        n_vec++;
        if (obs_strobes != 1) begin
            n_err++; $display("FAIL write_strobes got %0d want 1", obs_strobes);
        end
`ifdef POSTED_WRITE_EN
        n_vec++;
        if ({obs_ready_post, obs_valid_post} !== 2'b10) begin
            n_err++; $display("FAIL posted_ready got %b want 10", {obs_ready_post, obs_valid_post});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (bus.rsp_valid !== 1'b0) begin
                n_err++; $display("FAIL posted_no_rsp got %b want 0", bus.rsp_valid);
            end
        end
`else
        n_vec++;
        if (obs_lat != 1) begin
            n_err++; $display("FAIL write_latency got %0d cycles want 2", obs_lat + 1);
        end
        n_vec++;
        if ({obs_write, obs_data, obs_set, obs_tag} !== {1'b1, 32'h1234_5678, 3'd4, 27'h0}) begin
            n_err++; $display("FAIL write_rsp got %h want %h", {obs_write, obs_data, obs_set, obs_tag},
                              {1'b1, 32'h1234_5678, 3'd4, 27'h0});
        end
`endif
    endtask

    task automatic test_stall();
        logic [31:0] e;
        e = exp_read(32'h0000_0058);
        do_txn(1'b0, 32'h0000_0058, 32'h0, 5);
        n_vec++;
        if (obs_stable !== 1'b1) begin
            n_err++; $display("FAIL stall_stable got %b want 1", obs_stable);
        end
        n_vec++;
        if (obs_strobes != 1 || obs_data !== e) begin
            n_err++; $display("FAIL stall_strobes got %0d data %h want 1 data %h", obs_strobes, obs_data, e);
        end
        n_vec++;
        if ({obs_ready_hs, obs_valid_hs} !== 2'b10) begin
            n_err++; $display("FAIL stall_release got %b want 10", {obs_ready_hs, obs_valid_hs});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, w, e;
        int s0, n;
        a = 32'h0000_0288; w = 32'hA5C3_1E77;
        e = exp_read(a);
        s0 = strobe_cnt;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a; bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin tick(); n++; end
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin tick(); n++; end
        n_vec++;
        if (n != LAT + 1 || bus.rsp_data !== e || bus.req_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_read got lat %0d data %h rdy %b want %0d %h 0",
                              n + 1, bus.rsp_data, bus.req_ready, LAT + 2, e);
        end
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a; bus.req_wdata = w;
        tick();
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
            n_err++; $display("FAIL b2b_after_hs got %b want 10", {bus.req_ready, bus.rsp_valid});
        end
        tick();
        bus.req_valid = 1'b0;
        ref_mem[30'(a >> 2)] = w;
        n_vec++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, bus.req_ready} !== {2'b11, a, w, 1'b0}) begin
            n_err++; $display("FAIL b2b_second_accept got %h want %h",
                              {mem_en, mem_we, mem_addr, mem_wdata, bus.req_ready}, {2'b11, a, w, 1'b0});
        end
        tick();
`ifdef POSTED_WRITE_EN
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
            n_err++; $display("FAIL b2b_posted got %b want 10", {bus.req_ready, bus.rsp_valid});
        end
`else
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_write, bus.rsp_data} !== {2'b11, w}) begin
            n_err++; $display("FAIL b2b_write_rsp got %h want %h",
                              {bus.rsp_valid, bus.rsp_write, bus.rsp_data}, {2'b11, w});
        end
        tick();
`endif
        bus.rsp_ready = 1'b0;
        n_vec++;
        if (strobe_cnt - s0 != 2) begin
            n_err++; $display("FAIL b2b_strobes got %0d want 2", strobe_cnt - s0);
        end
        do_txn(1'b0, a, 32'h0, 0);
        n_vec++;
        if (obs_data !== w) begin
            n_err++; $display("FAIL b2b_order got %h want %h", obs_data, w);
        end
    endtask

    task automatic test_reset_mid();
        logic [130:0] rv;
        int s0, n;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h0000_0164; bus.rsp_ready = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 50) begin tick(); n++; end
        tick();
        bus.req_valid = 1'b0;
        tick();
        s0 = strobe_cnt;
        rst_n = 1'b0;
        #1;
        rv = {bus.req_ready, bus.rsp_valid, bus.rsp_write, bus.rsp_set, bus.rsp_tag, bus.rsp_data,
              mem_en, mem_we, mem_addr, mem_wdata};
        n_vec++;
        if (rv !== {1'b1, 130'b0}) begin
            n_err++; $display("FAIL midreset_values got %h want %h", rv, {1'b1, 130'b0});
        end
        ref_mem.delete();
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
                n_err++; $display("FAIL midreset_no_rsp got %b want 01", {bus.rsp_valid, bus.req_ready});
            end
        end
        n_vec++;
        if (strobe_cnt - s0 != 0) begin
            n_err++; $display("FAIL midreset_strobes got %0d want 0", strobe_cnt - s0);
        end
    endtask

    task automatic test_random();
        logic [26:0] tag_pool [4];
        logic        we;
        logic [31:0] a, wd, e;
        int          st;
        for (int i = 0; i < 4; i++) tag_pool[i] = {20'($urandom()), 7'(i + 8)};
        for (int it = 0; it < 40; it++) begin
            we = 1'($urandom_range(0, 1));
            a  = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            wd = $urandom();
            st = $urandom_range(0, 3);
            e  = we ? wd : exp_read(a);
            do_txn(we, a, wd, st);
            if (we) ref_mem[30'(a >> 2)] = wd;
            n_vec++;
            if ({obs_timeout, obs_first_en, obs_first_we, obs_first_addr, obs_busy_ready} !==
                {2'b01, we, a & ~32'h3, 1'b0}) begin
                n_err++; $display("FAIL rnd%0d_strobe got %h want %h", it,
                    {obs_timeout, obs_first_en, obs_first_we, obs_first_addr, obs_busy_ready},
                    {2'b01, we, a & ~32'h3, 1'b0});
            end
            n_vec++;
            if (obs_strobes != 1 || (we && obs_first_wdata !== wd)) begin
                n_err++; $display("FAIL rnd%0d_strobes got %0d wdata %h want 1 wdata %h", it,
                                  obs_strobes, obs_first_wdata, wd);
            end
`ifdef POSTED_WRITE_EN
            if (we) begin
                n_vec++;
                if ({obs_ready_post, obs_valid_post} !== 2'b10) begin
                    n_err++; $display("FAIL rnd%0d_posted got %b want 10", it, {obs_ready_post, obs_valid_post});
                end
                continue;
            end
`endif
            n_vec++;
            if (obs_lat != (we ? 1 : LAT + 1)) begin
                n_err++; $display("FAIL rnd%0d_latency got %0d want %0d", it, obs_lat + 1,
                                  we ? 2 : LAT + 2);
            end
            n_vec++;
            if ({obs_write, obs_set, obs_tag, obs_data} !== {we, exp_set(a), exp_tag(a), e}) begin
                n_err++; $display("FAIL rnd%0d_rsp got %h want %h", it, {obs_write, obs_set, obs_tag, obs_data},
                                  {we, exp_set(a), exp_tag(a), e});
            end
            n_vec++;
            if ({obs_stable, obs_ready_hs, obs_valid_hs} !== 3'b110) begin
                n_err++; $display("FAIL rnd%0d_handshake got %b want 110", it,
                                  {obs_stable, obs_ready_hs, obs_valid_hs});
            end
        end
        n_vec++;
        if (en_run_err != 0) begin
            n_err++; $display("FAIL mem_en_single got %0d runs want 0", en_run_err);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
